// File: rtl/gat_feat_reader.sv
// gat_feat_fifo: small synchronous FIFO, registered pointers and occupancy count.
// Latency: a pushed word is visible at the head on the cycle after the push.
// Backpressure: the producer must respect count; a push into a full FIFO is flagged by assertion.
module gat_feat_fifo #(
    parameter int  W     = 33,
    parameter int  DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [W-1:0]     push_dat,
    input  logic             pop_vld,
    output logic [W-1:0]     head_dat,
    output logic [CNT_W-1:0] count,
    output logic             empty
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;
    logic             full;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop_vld && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_vld, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is only consumed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_vld)
            mem[wr_ptr] <= push_dat;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_vld && full));

endmodule

// gat_feat_reader: sweeps the output-feature BRAM in ascending word order onto a valid/ready stream.
// Latency: first beat RD_LATENCY+1 cycles after entering READ, then one word per cycle.
// Backpressure: m_ready stalls the stream; reads are credit-limited so the output FIFO never overflows.
module gat_feat_reader #(
    parameter int NEW_FEATURE_WIDTH  = 32,
    parameter int NUM_SUBGRAPHS      = 2708,
    parameter int NUM_FEATURE_OUT    = 16,
    parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int RD_LATENCY         = 2,
    parameter int FIFO_DEPTH         = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          gat_ready,
    output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
    output logic [NEW_FEATURE_WIDTH-1:0]  m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,
    output logic                          busy,
    output logic                          done
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [NEW_FEATURE_ADDR_W-1:0] LAST_IDX = NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        READ,
        DRAIN,
        FIN
    } state_t;

    state_t                        state_q;
    state_t                        state_d;
    logic [NEW_FEATURE_ADDR_W-1:0] rd_idx;
    logic [RD_LATENCY-1:0]         lat_vld;
    logic [RD_LATENCY-1:0]         lat_last;
    logic [CNT_W-1:0]              inflight;
    logic [CNT_W-1:0]              fifo_count;
    logic                          fifo_empty;
    logic [NEW_FEATURE_WIDTH:0]    fifo_head;
    logic                          credit_ok;
    logic                          issue;
    logic                          issue_last;

    // Every read in flight has a FIFO slot reserved, so a returning word always fits.
    assign credit_ok  = ({1'b0, inflight} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign issue      = (state_q == READ) && credit_ok;
    assign issue_last = issue && (rd_idx == LAST_IDX);

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++)
            inflight = inflight + CNT_W'(lat_vld[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (gat_ready)
                    state_d = READ;
            end
            READ: begin
                if (issue_last)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if ((inflight == '0) && fifo_empty)
                    state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == WAIT_RDY) || (state_q == READ) || (state_q == DRAIN);
    assign done = (state_q == FIN);

    // rd_idx saturates on the final word; it is rewound when a new start is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx          <= '0;
            feat_bram_addrb <= '0;
        end else begin
            if ((state_q == IDLE) && start)
                rd_idx <= '0;
            else if (issue && (rd_idx != LAST_IDX))
                rd_idx <= rd_idx + NEW_FEATURE_ADDR_W'(1);
            if (issue)
                feat_bram_addrb <= {rd_idx, 2'b00};
        end
    end

    // Read-latency tracker: a tag leaving the last stage marks the cycle dout is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_vld  <= '0;
            lat_last <= '0;
        end else begin
            lat_vld[0]  <= issue;
            lat_last[0] <= issue_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                lat_vld[i]  <= lat_vld[i-1];
                lat_last[i] <= lat_last[i-1];
            end
        end
    end

    gat_feat_fifo #(
        .W     (NEW_FEATURE_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (lat_vld[RD_LATENCY-1]),
        .push_dat ({lat_last[RD_LATENCY-1], feat_bram_dout}),
        .pop_vld  (m_ready),
        .head_dat (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = m_valid ? fifo_head[NEW_FEATURE_WIDTH-1:0] : '0;
    assign m_last  = m_valid && fifo_head[NEW_FEATURE_WIDTH];

endmodule

// File: tb/tb_gat_feat_reader.sv
// Directed bench for gat_feat_reader: 8-word BRAM, read latency 2, 4-entry output FIFO.
module tb_gat_feat_reader;
    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int FD    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          gat_ready;
    logic [AW+1:0] feat_bram_addrb;
    logic [W-1:0]  feat_bram_dout;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          done;

    gat_feat_reader #(
        .NEW_FEATURE_WIDTH (W),
        .NUM_SUBGRAPHS     (2),
        .NUM_FEATURE_OUT   (4),
        .RD_LATENCY        (2),
        .FIFO_DEPTH        (FD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .gat_ready       (gat_ready),
        .feat_bram_addrb (feat_bram_addrb),
        .feat_bram_dout  (feat_bram_dout),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_last          (m_last),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    // One registered stage: word valid two cycles after the cycle its read issues.
    always @(posedge clk) feat_bram_dout <= 32'hA000_0000 + 32'(feat_bram_addrb >> 2);

    int            checks = 0;
    int            passes = 0;
    int            cyc = 0;
    int            beats = 0;
    int            runs = 0;
    int            done_cnt = 0;
    int            last_beat_cyc = -10;
    logic [W:0]    sb [$];
    logic [W:0]    exp_beat;
    logic          prev_vld = 1'b0;
    logic          prev_rdy = 1'b0;
    logic          prev_last = 1'b0;
    logic          prev_done = 1'b0;
    logic [W-1:0]  prev_dat = '0;
    logic [AW+1:0] prev_addrb = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_pass();
        for (int i = 0; i < DEPTH; i++)
            sb.push_back({(i == DEPTH - 1), 32'hA000_0000 + 32'(i)});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit rand_rdy);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            if (rand_rdy)
                m_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        m_ready = 1'b1;
        step(2);
        check(tag, 64'(done_cnt - d0), 64'd1);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addrb"}, 64'(feat_bram_addrb), 64'd0);
        check({tag, "_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_last"}, 64'(m_last), 64'd0);
        check({tag, "_data"}, 64'(m_data), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    task monitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_vld   = 1'b0;
                prev_done  = 1'b0;
                prev_addrb = '0;
            end else begin
                if (prev_vld && !prev_rdy) begin
                    check("valid_hold", 64'(m_valid), 64'd1);
                    check("data_hold", 64'(m_data), 64'(prev_dat));
                    check("last_hold", 64'(m_last), 64'(prev_last));
                end
                if (feat_bram_addrb !== prev_addrb) begin
                    check("addrb_step", 64'(feat_bram_addrb),
                          64'((prev_addrb == 5'd28) ? 5'd0 : prev_addrb + 5'd4));
                    prev_addrb = feat_bram_addrb;
                end
                check("credit", 64'((int'(dut.inflight) + int'(dut.fifo_count)) <= FD), 64'd1);
                if (m_valid && m_ready) begin
                    check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        exp_beat = sb.pop_front();
                        check("beat_data", 64'(m_data), 64'(exp_beat[W-1:0]));
                        check("beat_last", 64'(m_last), 64'(exp_beat[W]));
                    end
                    if (cyc != last_beat_cyc + 1)
                        runs++;
                    last_beat_cyc = cyc;
                    beats++;
                end
                if (done) begin
                    done_cnt++;
                    check("done_single", 64'(prev_done), 64'd0);
                    check("sb_drained", 64'(sb.size()), 64'd0);
                end
                prev_vld  = m_valid;
                prev_rdy  = m_ready;
                prev_dat  = m_data;
                prev_last = m_last;
                prev_done = done;
            end
        end
    endtask

    initial begin
        int lat;
        int n;
        int b0;
        int r0;
        int d0;
        rst_n     = 1'b0;
        start     = 1'b0;
        gat_ready = 1'b0;
        m_ready   = 1'b0;
        fork
            monitor();
        join_none
        step(3);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        step(2);

        // Ready already high, sink always ready
        gat_ready = 1'b1;
        m_ready   = 1'b1;
        b0 = beats;
        r0 = runs;
        push_pass();
        pulse_start();
        check("s1_busy", 64'(busy), 64'd1);
        lat = 0;
        while (!m_valid && lat < 20) begin
            step();
            lat++;
        end
        check("s1_first_valid_lat", 64'(lat), 64'd4);
        wait_done("s1_done", 60, 1'b0);
        check("s1_beats", 64'(beats - b0), 64'd8);
        check("s1_back_to_back", 64'(runs - r0), 64'd1);
        check("s1_addrb_final", 64'(feat_bram_addrb), 64'd28);

        // Accelerator not ready for 10 cycles
        gat_ready = 1'b0;
        b0 = beats;
        push_pass();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            check("s2_wait_addrb", 64'(feat_bram_addrb), 64'd28);
            check("s2_wait_valid", 64'(m_valid), 64'd0);
            step();
        end
        gat_ready = 1'b1;
        r0 = runs;
        wait_done("s2_done", 60, 1'b0);
        check("s2_beats", 64'(beats - b0), 64'd8);
        check("s2_back_to_back", 64'(runs - r0), 64'd1);

        // Sink stalled for the whole read phase
        m_ready = 1'b0;
        b0 = beats;
        push_pass();
        pulse_start();
        step(12);
        check("s3_addrb_stall", 64'(feat_bram_addrb), 64'd12);
        check("s3_fifo_full", 64'(dut.fifo_count), 64'd4);
        check("s3_head", 64'(m_data), 64'hA000_0000);
        check("s3_no_beats", 64'(beats - b0), 64'd0);
        m_ready = 1'b1;
        wait_done("s3_done", 60, 1'b0);
        check("s3_beats", 64'(beats - b0), 64'd8);

        // Random backpressure
        b0 = beats;
        push_pass();
        pulse_start();
        wait_done("s4_done", 400, 1'b1);
        check("s4_beats", 64'(beats - b0), 64'd8);

        // Reset in the middle of a pass
        m_ready = 1'b1;
        b0 = beats;
        d0 = done_cnt;
        push_pass();
        pulse_start();
        n = 0;
        while ((beats - b0) < 3 && n < 40) begin
            step();
            n++;
        end
        check("s5_reached_3", 64'((beats - b0) >= 3), 64'd1);
        rst_n = 1'b0;
        step();
        check_reset_outputs("s5_rst");
        step(2);
        sb.delete();
        check("s5_no_done", 64'(done_cnt - d0), 64'd0);
        rst_n = 1'b1;
        step(2);
        b0 = beats;
        push_pass();
        pulse_start();
        wait_done("s5_done", 60, 1'b0);
        check("s5_beats", 64'(beats - b0), 64'd8);

        // Start while busy is ignored; start after done runs a full second pass
        b0 = beats;
        push_pass();
        pulse_start();
        step(3);
        pulse_start();
        wait_done("s6_done", 60, 1'b0);
        check("s6_beats", 64'(beats - b0), 64'd8);
        step(10);
        check("s6_no_restart_busy", 64'(busy), 64'd0);
        check("s6_no_restart_valid", 64'(m_valid), 64'd0);
        b0 = beats;
        push_pass();
        pulse_start();
        wait_done("s6_rerun_done", 60, 1'b0);
        check("s6_rerun_beats", 64'(beats - b0), 64'd8);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", passes, checks);
        $fatal(1, "watchdog");
    end

endmodule
